// File: rtl/memShare_config_pkg.sv
// Shared memShare configuration: DRC flag layout and the read-side address width,
// which the message-pass writer reuses as its offset counter width.
package memShare_config_pkg;

   localparam int MEMSHARE_DRC_NUM      = 2;
   localparam int MEMSHARE_DRC1         = 1;
   localparam int MSGPASS_RD_ADDR_WIDTH = 8;

endpackage

// File: rtl/msgPass_config_pkg.sv
// Message-pass buffer configuration: buffer address width, default burst-length
// width and the write-side FSM state type.
package msgPass_config_pkg;

   localparam int MSGPASS_BUFF_ADDR_WIDTH = 8;
   localparam int MSGPASS_WR_LEN_WIDTH    = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } wr_state_e;

endpackage

// File: rtl/msgPass_wr_offset_cnt.sv
// Offset and write-count registers for one write burst, with the stride/unit
// increment select and detection of the final write.
module msgPass_wr_offset_cnt #(
   parameter int OFFSET_WIDTH = 8,
   parameter int LEN_WIDTH    = 8
) (
   input  logic                    sys_clk,
   input  logic                    rstn,
   input  logic                    clear,
   input  logic                    advance,
   input  logic                    use_stride,
   input  logic [OFFSET_WIDTH-1:0] stride,
   input  logic [LEN_WIDTH-1:0]    len,
   output logic [OFFSET_WIDTH-1:0] offset,
   output logic                    is_last
);

   logic [OFFSET_WIDTH-1:0] step;
   logic [LEN_WIDTH-1:0]    count;

   assign step = use_stride ? stride : OFFSET_WIDTH'(1);

   // Offset wraps silently at 2^OFFSET_WIDTH; clear has priority over advance.
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         offset <= '0;
         count  <= '0;
      end else if (clear) begin
         offset <= '0;
         count  <= '0;
      end else if (advance) begin
         offset <= offset + step;
         count  <= count + LEN_WIDTH'(1);
      end
   end

   assign is_last = (count == (len - LEN_WIDTH'(1)));

endmodule

// File: rtl/msgpass_wr_addr_gen.sv
// Message-pass buffer write-address generator: one registered strobe/address per
// accepted message. Optional sticky overrun flag under MSGPASS_WR_OVERRUN_CHK_EN.
module msgpass_wr_addr_gen
   import msgPass_config_pkg::*;
   import memShare_config_pkg::*;
#(
   parameter int ADDR_WIDTH   = msgPass_config_pkg::MSGPASS_BUFF_ADDR_WIDTH,
   parameter int OFFSET_WIDTH = memShare_config_pkg::MSGPASS_RD_ADDR_WIDTH,
   parameter int LEN_WIDTH    = msgPass_config_pkg::MSGPASS_WR_LEN_WIDTH
) (
   input  logic                        sys_clk,
   input  logic                        rstn,
   input  logic                        buffer_write_begin_i,
   input  logic                        buffer_write_end_i,
   input  logic [ADDR_WIDTH-1:0]       base_addr_i,
   input  logic [LEN_WIDTH-1:0]        wr_len_i,
   input  logic [MEMSHARE_DRC_NUM-1:0] is_drc_i,
   input  logic [OFFSET_WIDTH-1:0]     drc_stride_i,
   input  logic                        wr_valid_i,
   output logic                        wr_ready_o,
   output logic                        wr_en_o,
   output logic [ADDR_WIDTH-1:0]       addr_o,
   output logic                        wr_last_o,
   output logic                        done_o
`ifdef MSGPASS_WR_OVERRUN_CHK_EN
   ,
   output logic                        overrun_err_o
`endif
);

   wr_state_e               state, state_next;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [LEN_WIDTH-1:0]    len_q;
   logic [OFFSET_WIDTH-1:0] offset;
   logic                    is_last;
   logic                    accept;
   logic                    zero_len_begin;
   logic                    unused_drc;

   assign unused_drc     = ^is_drc_i;
   assign wr_ready_o     = (state == ACTIVE) & ~buffer_write_end_i & ~buffer_write_begin_i;
   assign accept         = wr_valid_i & wr_ready_o;
   assign zero_len_begin = buffer_write_begin_i & ~buffer_write_end_i & (wr_len_i == '0);

   msgPass_wr_offset_cnt #(
      .OFFSET_WIDTH (OFFSET_WIDTH),
      .LEN_WIDTH    (LEN_WIDTH)
   ) u_offset_cnt (
      .sys_clk    (sys_clk),
      .rstn       (rstn),
      .clear      (buffer_write_begin_i),
      .advance    (accept),
      .use_stride (is_drc_i[MEMSHARE_DRC1]),
      .stride     (drc_stride_i),
      .len        (len_q),
      .offset     (offset),
      .is_last    (is_last)
   );

   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         state  <= IDLE;
         base_q <= '0;
         len_q  <= '0;
      end else begin
         state <= state_next;
         if (buffer_write_begin_i) begin
            base_q <= base_addr_i;
            len_q  <= wr_len_i;
         end
      end
   end

   // Abort beats restart, restart beats completion of the current burst.
   always_comb begin
      state_next = state;
      if (buffer_write_end_i) begin
         state_next = IDLE;
      end else if (buffer_write_begin_i) begin
         state_next = (wr_len_i != '0) ? ACTIVE : IDLE;
      end else if (accept && is_last) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         wr_en_o   <= 1'b0;
         addr_o    <= '0;
         wr_last_o <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         wr_en_o   <= accept;
         wr_last_o <= accept & is_last;
         done_o    <= (accept & is_last) | zero_len_begin;
         if (accept) begin
            addr_o <= base_q + ADDR_WIDTH'(offset);
         end
      end
   end

`ifdef MSGPASS_WR_OVERRUN_CHK_EN
   // Sticky until the next burst start; ready is never high in IDLE.
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         overrun_err_o <= 1'b0;
      end else if (buffer_write_begin_i) begin
         overrun_err_o <= 1'b0;
      end else if ((state == IDLE) && wr_valid_i && !wr_ready_o) begin
         overrun_err_o <= 1'b1;
      end
   end
`endif

endmodule
